// File: rtl/seg7_capture_if.sv
// rtl/seg7_capture_if.sv - 7-segment capture bus: raw display lines in, decoded frame out
interface seg7_capture_if #(
    parameter int NDIG = 4
);
    logic [6:0]        segs_in;
    logic [NDIG-1:0]   an_in;
    logic [4*NDIG-1:0] value;
    logic              valid;
    logic              err;
    logic [NDIG-1:0]   bad_dig;

    modport master (
        output segs_in,
        output an_in,
        input  value,
        input  valid,
        input  err,
        input  bad_dig
    );

    modport slave (
        input  segs_in,
        input  an_in,
        output value,
        output valid,
        output err,
        output bad_dig
    );
endinterface

// File: rtl/seg7_capture.sv
// rtl/seg7_capture.sv - recovers hex digits from a multiplexed 7-segment scan bus
module seg7_capture #(
    parameter int NDIG   = 4,
    parameter int STABLE = 4
) (
    input logic          clk,
    input logic          rst,
    seg7_capture_if.slave bus
);
    localparam int            CW      = (STABLE > 1) ? $clog2(STABLE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE - 1);

    logic [6:0]        seg_m_q, seg_m_d, seg_s_q, seg_s_d;
    logic [NDIG-1:0]   an_m_q, an_m_d, an_s_q, an_s_d;
    logic [6:0]        prev_seg_q, prev_seg_d;
    logic [NDIG-1:0]   prev_an_q, prev_an_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              armed_q, armed_d;
    logic [NDIG-1:0]   seen_q, seen_d;
    logic [4*NDIG-1:0] shadow_q, shadow_d;
    logic [NDIG-1:0]   shbad_q, shbad_d;
    logic [4*NDIG-1:0] value_q, value_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [NDIG-1:0]   bad_q, bad_d;

    logic              one_hot;
    logic              same;
    logic              capture;
    logic              frame_done;
    logic [4:0]        dec;

    // Returns {bad, digit}; anything outside the 16 legal glyphs decodes as a bad 0.
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h3F:   r = 5'h00;
            7'h06:   r = 5'h01;
            7'h5B:   r = 5'h02;
            7'h4F:   r = 5'h03;
            7'h66:   r = 5'h04;
            7'h6D:   r = 5'h05;
            7'h7D:   r = 5'h06;
            7'h07:   r = 5'h07;
            7'h7F:   r = 5'h08;
            7'h6F:   r = 5'h09;
            7'h77:   r = 5'h0A;
            7'h7C:   r = 5'h0B;
            7'h39:   r = 5'h0C;
            7'h5E:   r = 5'h0D;
            7'h79:   r = 5'h0E;
            7'h71:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    always_comb begin
        seg_m_d    = bus.segs_in;
        seg_s_d    = seg_m_q;
        an_m_d     = bus.an_in;
        an_s_d     = an_m_q;
        prev_seg_d = seg_s_q;
        prev_an_d  = an_s_q;

        one_hot    = $onehot(an_s_q);
        same       = one_hot && (an_s_q == prev_an_q) && (seg_s_q == prev_seg_q);
        dec        = decode(seg_s_q);
        frame_done = &seen_q;

        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (!same) begin
            cnt_d   = '0;
            armed_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        // A change this cycle re-arms immediately, so STABLE=1 captures on the first sample.
        capture = one_hot && (cnt_d == CNT_MAX) && (armed_q || !same);
        if (capture) begin
            armed_d = 1'b0;
        end

        shadow_d = shadow_q;
        shbad_d  = shbad_q;
        seen_d   = frame_done ? '0 : seen_q;
        if (capture) begin
            for (int i = 0; i < NDIG; i++) begin
                if (an_s_q[i]) begin
                    shadow_d[4*i +: 4] = dec[3:0];
                    shbad_d[i]         = dec[4];
                end
            end
            seen_d = seen_d | an_s_q;
        end

        value_d = value_q;
        bad_d   = bad_q;
        err_d   = err_q;
        valid_d = 1'b0;
        if (frame_done) begin
            value_d = shadow_q;
            bad_d   = shbad_q;
            err_d   = |shbad_q;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_m_q    <= '0;
            seg_s_q    <= '0;
            an_m_q     <= '0;
            an_s_q     <= '0;
            prev_seg_q <= '0;
            prev_an_q  <= '0;
            cnt_q      <= '0;
            armed_q    <= 1'b1;
            seen_q     <= '0;
            shadow_q   <= '0;
            shbad_q    <= '0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            bad_q      <= '0;
        end else begin
            seg_m_q    <= seg_m_d;
            seg_s_q    <= seg_s_d;
            an_m_q     <= an_m_d;
            an_s_q     <= an_s_d;
            prev_seg_q <= prev_seg_d;
            prev_an_q  <= prev_an_d;
            cnt_q      <= cnt_d;
            armed_q    <= armed_d;
            seen_q     <= seen_d;
            shadow_q   <= shadow_d;
            shbad_q    <= shbad_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            bad_q      <= bad_d;
        end
    end

    assign bus.value   = value_q;
    assign bus.valid   = valid_q;
    assign bus.err     = err_q;
    assign bus.bad_dig = bad_q;
endmodule

// File: tb/tb_seg7_capture.sv
// tb/tb_seg7_capture.sv - directed-vector bench for seg7_capture
module tb_seg7_capture;
    localparam int NDIG = 4;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   valid_cnt;
    logic [15:0] last_value;
    logic        last_err;
    logic [3:0]  last_bad;

    seg7_capture_if #(.NDIG(NDIG)) bus ();

    seg7_capture #(.NDIG(NDIG), .STABLE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && bus.valid) begin
            valid_cnt  = valid_cnt + 1;
            last_value = bus.value;
            last_err   = bus.err;
            last_bad   = bus.bad_dig;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int k, input logic [6:0] seg, input int n);
        bus.an_in   = 4'(1 << k);
        bus.segs_in = seg;
        cycles(n);
    endtask

    task automatic idle(input int n);
        bus.an_in   = '0;
        bus.segs_in = '0;
        cycles(n);
    endtask

    task automatic test_reset();
        tests++; if (bus.value !== 16'h0) begin fails++; $display("FAIL reset_value: got %h want 0000", bus.value); end
        tests++; if (bus.valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
        tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", bus.err); end
        tests++; if (bus.bad_dig !== 4'h0) begin fails++; $display("FAIL reset_bad: got %b want 0000", bus.bad_dig); end
    endtask

    task automatic test_basic_frame();
        valid_cnt = 0;
        strobe(0, 7'h4F, 8);
        strobe(1, 7'h77, 8);
        strobe(2, 7'h3F, 8);
        strobe(3, 7'h71, 8);
        idle(4);
        tests++; if (valid_cnt !== 1) begin fails++; $display("FAIL basic_pulses: got %0d want 1", valid_cnt); end
        tests++; if (last_value !== 16'hF0A3) begin fails++; $display("FAIL basic_value: got %h want f0a3", last_value); end
        tests++; if (bus.value !== 16'hF0A3) begin fails++; $display("FAIL basic_hold: got %h want f0a3", bus.value); end
        tests++; if (last_err !== 1'b0 || last_bad !== 4'h0) begin fails++; $display("FAIL basic_err: got err=%b bad=%b want 0 0000", last_err, last_bad); end
    endtask

    task automatic test_blank_digit();
        valid_cnt = 0;
        strobe(0, 7'h06, 8);
        strobe(1, 7'h5B, 8);
        strobe(2, 7'h00, 8);
        strobe(3, 7'h66, 8);
        idle(4);
        tests++; if (valid_cnt !== 1) begin fails++; $display("FAIL blank_pulses: got %0d want 1", valid_cnt); end
        tests++; if (last_value !== 16'h4021) begin fails++; $display("FAIL blank_value: got %h want 4021", last_value); end
        tests++; if (last_bad !== 4'b0100) begin fails++; $display("FAIL blank_bad: got %b want 0100", last_bad); end
        tests++; if (last_err !== 1'b1) begin fails++; $display("FAIL blank_err: got %b want 1", last_err); end
    endtask

    task automatic test_glitch();
        valid_cnt = 0;
        bus.an_in = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            bus.segs_in = i[0] ? 7'h06 : 7'h3F;
            cycles(2);
        end
        bus.an_in   = 4'b0011;
        bus.segs_in = 7'h3F;
        cycles(20);
        idle(2);
        strobe(1, 7'h06, 8);
        strobe(2, 7'h5B, 8);
        strobe(3, 7'h4F, 8);
        idle(4);
        tests++; if (valid_cnt !== 0) begin fails++; $display("FAIL glitch_no_frame: got %0d pulses want 0", valid_cnt); end
        strobe(0, 7'h7F, 8);
        idle(4);
        tests++; if (valid_cnt !== 1) begin fails++; $display("FAIL glitch_pulses: got %0d want 1", valid_cnt); end
        tests++; if (last_value !== 16'h3218) begin fails++; $display("FAIL glitch_value: got %h want 3218", last_value); end
    endtask

    task automatic test_restrobe();
        valid_cnt = 0;
        strobe(0, 7'h06, 8);
        strobe(0, 7'h6D, 8);
        strobe(1, 7'h7D, 8);
        strobe(2, 7'h07, 8);
        strobe(3, 7'h7F, 8);
        idle(4);
        tests++; if (valid_cnt !== 1) begin fails++; $display("FAIL restrobe_pulses: got %0d want 1", valid_cnt); end
        tests++; if (last_value !== 16'h8765) begin fails++; $display("FAIL restrobe_value: got %h want 8765", last_value); end
        tests++; if (last_err !== 1'b0) begin fails++; $display("FAIL restrobe_err: got %b want 0", last_err); end
    endtask

    task automatic test_back_to_back();
        valid_cnt = 0;
        strobe(0, 7'h6F, 100);
        strobe(1, 7'h77, 8);
        strobe(2, 7'h7C, 8);
        strobe(3, 7'h39, 8);
        tests++; if (valid_cnt !== 1) begin fails++; $display("FAIL b2b_first_pulses: got %0d want 1", valid_cnt); end
        tests++; if (last_value !== 16'hCBA9) begin fails++; $display("FAIL b2b_first_value: got %h want cba9", last_value); end
        strobe(0, 7'h5E, 8);
        strobe(1, 7'h79, 8);
        strobe(2, 7'h71, 8);
        strobe(3, 7'h4F, 8);
        idle(4);
        tests++; if (valid_cnt !== 2) begin fails++; $display("FAIL b2b_pulses: got %0d want 2", valid_cnt); end
        tests++; if (last_value !== 16'h3FED) begin fails++; $display("FAIL b2b_second_value: got %h want 3fed", last_value); end
        tests++; if (last_bad !== 4'h0) begin fails++; $display("FAIL b2b_bad: got %b want 0000", last_bad); end
    endtask

    task automatic test_reset_midframe();
        valid_cnt = 0;
        strobe(0, 7'h3F, 8);
        strobe(1, 7'h06, 8);
        #3;
        rst = 1'b1;
        #1;
        tests++; if (bus.value !== 16'h0) begin fails++; $display("FAIL midrst_value: got %h want 0000", bus.value); end
        tests++; if (bus.valid !== 1'b0 || bus.err !== 1'b0) begin fails++; $display("FAIL midrst_flags: got valid=%b err=%b want 0 0", bus.valid, bus.err); end
        cycles(2);
        rst = 1'b0;
        idle(2);
        strobe(2, 7'h5B, 8);
        strobe(3, 7'h4F, 8);
        idle(4);
        tests++; if (valid_cnt !== 0) begin fails++; $display("FAIL midrst_no_frame: got %0d pulses want 0", valid_cnt); end
        strobe(0, 7'h66, 8);
        strobe(1, 7'h6D, 8);
        idle(4);
        tests++; if (valid_cnt !== 1) begin fails++; $display("FAIL midrst_pulses: got %0d want 1", valid_cnt); end
        tests++; if (last_value !== 16'h3254) begin fails++; $display("FAIL midrst_value_after: got %h want 3254", last_value); end
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        valid_cnt   = 0;
        last_value  = '0;
        last_err    = 1'b0;
        last_bad    = '0;
        rst         = 1'b1;
        bus.an_in   = '0;
        bus.segs_in = '0;
        cycles(3);
        test_reset();
        rst = 1'b0;
        idle(2);
        test_basic_frame();
        test_blank_digit();
        test_glitch();
        test_restrobe();
        test_back_to_back();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
